// File: rtl/run_ctrl_pkg.sv
// Shared state encoding for the CPU run/step/breakpoint controller.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_BRK  = 2'b11
  } state_t;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 32;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with rising-edge detect on the synchronized level.
// o_sync lags the pin by two edges; o_rise is combinational from the sync flops.
module sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;
  logic [W-1:0] r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/run_ctrl.sv
// CPU clock-enable controller: run/step/halt with optional PC breakpoint (RUN_CTRL_BRK_EN).
// Pin to cpu_en latency is 3 edges; the breakpoint gates cpu_en combinationally in the matching cycle.
module run_ctrl
  import run_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic [ADDR_W-1:0] pc,
  input  logic              brk_set,
  input  logic              brk_clr,
  input  logic [ADDR_W-1:0] brk_wdata,
  input  logic              cnt_clr,
  output logic              cpu_en,
  output logic              halted,
  output logic [1:0]        state,
  output logic              brk_hit,
  output logic [CNT_W-1:0]  cyc_cnt
);

  state_t           r_state;
  state_t           w_next;
  logic             w_cpu_en;
  logic             w_match;
  logic             w_run_s;
  logic             w_step_rise;
  logic             w_unused_run_rise;
  logic             w_unused_step_s;
  logic [CNT_W-1:0] r_cyc_cnt;

  sync_edge #(.W(1)) u_sync_run (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (run),
    .o_sync  (w_run_s),
    .o_rise  (w_unused_run_rise)
  );

  sync_edge #(.W(1)) u_sync_step (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (step),
    .o_sync  (w_unused_step_s),
    .o_rise  (w_step_rise)
  );

`ifdef RUN_CTRL_BRK_EN
  logic [ADDR_W-1:0] r_brk_addr;
  logic              r_brk_valid;

  // Clear beats set for the valid bit, but the address is still captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_brk_addr  <= '0;
      r_brk_valid <= 1'b0;
    end else begin
      if (brk_set) r_brk_addr <= brk_wdata;
      if (brk_clr)      r_brk_valid <= 1'b0;
      else if (brk_set) r_brk_valid <= 1'b1;
    end
  end

  assign w_match = r_brk_valid && (pc == r_brk_addr);
  assign brk_hit = (r_state == ST_BRK);
`else
  logic w_unused_brk;
  assign w_unused_brk = ^{brk_set, brk_clr, brk_wdata, pc};
  assign w_match      = 1'b0;
  assign brk_hit      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_HALT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_cpu_en = 1'b0;
    case (r_state)
      ST_HALT: begin
        if (w_run_s)          w_next = ST_RUN;
        else if (w_step_rise) w_next = ST_STEP;
      end
      ST_RUN: begin
        // Step edges are dropped here; only the run level or a breakpoint moves us on.
        w_cpu_en = !w_match;
        if (!w_run_s)     w_next = ST_HALT;
        else if (w_match) w_next = ST_BRK;
      end
      ST_STEP: begin
        w_cpu_en = 1'b1;
        w_next   = ST_HALT;
      end
      ST_BRK: begin
`ifdef RUN_CTRL_BRK_EN
        if (w_step_rise)   w_next = ST_STEP;
        else if (!w_run_s) w_next = ST_HALT;
`else
        w_next = ST_HALT;
`endif
      end
      default: w_next = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_cyc_cnt <= '0;
    else if (cnt_clr)  r_cyc_cnt <= '0;
    else if (w_cpu_en) r_cyc_cnt <= r_cyc_cnt + 1'b1;
  end

  assign cpu_en  = w_cpu_en;
  assign halted  = (r_state == ST_HALT) || (r_state == ST_BRK);
  assign state   = r_state;
  assign cyc_cnt = r_cyc_cnt;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed plus randomized bench for run_ctrl against a cycle-level behavioural model.
module tb_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, run, step, brk_set, brk_clr, cnt_clr;
  logic [31:0] pc, brk_wdata, cyc_cnt;
  logic        cpu_en, halted, brk_hit;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_BRK = 3;

  int          m_mode;
  bit          m_run_h[2];
  bit          m_step_h[3];
  logic [31:0] m_cnt, m_baddr;
  bit          m_bval;

  always #5 clk = ~clk;

  run_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .pc(pc),
    .brk_set(brk_set), .brk_clr(brk_clr), .brk_wdata(brk_wdata), .cnt_clr(cnt_clr),
    .cpu_en(cpu_en), .halted(halted), .state(state), .brk_hit(brk_hit), .cyc_cnt(cyc_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_HALT;
    m_run_h = '{0, 0};
    m_step_h = '{0, 0, 0};
    m_cnt = '0;
    m_baddr = '0;
    m_bval = 0;
  endtask

  function automatic bit m_match();
`ifdef RUN_CTRL_BRK_EN
    return m_bval && (pc == m_baddr);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_en();
    return (m_mode == M_RUN && !m_match()) || (m_mode == M_STEP);
  endfunction

  task automatic check_all();
    chk("state", {30'd0, state}, 32'(m_mode));
    chk("cpu_en", {31'd0, cpu_en}, {31'd0, m_en()});
    chk("halted", {31'd0, halted}, {31'd0, (m_mode == M_HALT || m_mode == M_BRK)});
    chk("brk_hit", {31'd0, brk_hit}, {31'd0, (m_mode == M_BRK)});
    chk("cyc_cnt", cyc_cnt, m_cnt);
  endtask

  // One clock: predict from pre-edge inputs, advance the model, then compare.
  task automatic tick();
    bit en, rs, se, p_run, p_step, p_set, p_clr, p_cc;
    logic [31:0] p_wd;
    int nm;
    en = m_en();
    rs = m_run_h[1];
    se = m_step_h[1] && !m_step_h[2];
    nm = m_mode;
    case (m_mode)
      M_HALT: if (rs) nm = M_RUN; else if (se) nm = M_STEP;
      M_RUN:  if (!rs) nm = M_HALT; else if (m_match()) nm = M_BRK;
      M_STEP: nm = M_HALT;
      default: if (se) nm = M_STEP; else if (!rs) nm = M_HALT;
    endcase
    p_run = run; p_step = step; p_set = brk_set; p_clr = brk_clr; p_cc = cnt_clr; p_wd = brk_wdata;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      m_mode = nm;
      m_run_h[1] = m_run_h[0]; m_run_h[0] = p_run;
      m_step_h[2] = m_step_h[1]; m_step_h[1] = m_step_h[0]; m_step_h[0] = p_step;
      if (p_cc) m_cnt = '0; else if (en) m_cnt = m_cnt + 1;
      if (p_set) m_baddr = p_wd;
      if (p_clr) m_bval = 0; else if (p_set) m_bval = 1;
    end
    #1;
    brk_set = 0; brk_clr = 0; cnt_clr = 0;
    check_all();
  endtask

  initial begin
    int en_seen;
    bit flag;
    logic [31:0] pc_en;

    rst_n = 0; run = 0; step = 0; pc = '0; brk_set = 0; brk_clr = 0; brk_wdata = '0; cnt_clr = 0;
    model_reset();
    #1;
    check_all();
    chk("rst_halted", {31'd0, halted}, 32'd1);
    tick(); tick();
    rst_n = 1;

    // Single step from HALT.
    en_seen = 0;
    step = 1;
    for (int i = 0; i < 3; i++) begin tick(); if (cpu_en) en_seen++; end
    step = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (cpu_en) en_seen++; end
    chk("step_pulses", en_seen, 1);
    chk("step_cnt", cyc_cnt, 1);
    chk("step_state", {30'd0, state}, 0);

    // Run for ten enabled cycles.
    cnt_clr = 1; tick();
    en_seen = 0;
    run = 1;
    for (int i = 0; i < 10; i++) begin tick(); if (cpu_en) en_seen++; end
    run = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (cpu_en) en_seen++; end
    chk("run_pulses", en_seen, 10);
    chk("run_cnt", cyc_cnt, 10);
    chk("run_state", {30'd0, state}, 0);

`ifdef RUN_CTRL_BRK_EN
    // Breakpoint at 0x10 while PC ramps by 4 per enabled cycle.
    brk_wdata = 32'h10; brk_set = 1; pc = '0; tick();
    run = 1;
    flag = 0;
    for (int i = 0; i < 20; i++) begin
      bit adv;
      adv = cpu_en;
      tick();
      if (adv) pc = pc + 4;
      #1;
      if (state == 2'b01 && pc == 32'h10 && !cpu_en) flag = 1;
      if (state == 2'b11) break;
    end
    chk("brk_gate", {31'd0, flag}, 1);
    chk("brk_hit", {31'd0, brk_hit}, 1);
    chk("brk_state", {30'd0, state}, 32'd3);
    chk("brk_pc", pc, 32'h10);

    // Step past the breakpoint.
    step = 1; en_seen = 0; flag = 0; pc_en = '1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_en) begin en_seen++; pc_en = pc; end
      if (en_seen > 0 && state == 2'b00) begin flag = 1; break; end
    end
    step = 0;
    chk("brk_step_pulses", en_seen, 1);
    chk("brk_step_pc", pc_en, 32'h10);
    chk("brk_step_halt", {31'd0, flag}, 1);
    run = 0;
    for (int i = 0; i < 6; i++) tick();

    // Set and clear together: clear wins.
    brk_wdata = 32'h10; brk_set = 1; brk_clr = 1; tick();
    run = 1; pc = 32'h10; flag = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (state == 2'b11) flag = 1; end
    chk("setclr_nobrk", {31'd0, flag}, 0);
    chk("setclr_state", {30'd0, state}, 1);
    chk("setclr_en", {31'd0, cpu_en}, 1);
`else
    // Without breakpoint support a matching PC never stops the CPU.
    brk_wdata = 32'h20; brk_set = 1; pc = 32'h20; tick();
    run = 1; flag = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (state == 2'b11 || (state == 2'b01 && !cpu_en)) flag = 1; end
    chk("nobrk_flag", {31'd0, flag}, 0);
    chk("nobrk_state", {30'd0, state}, 1);
    chk("nobrk_hit", {31'd0, brk_hit}, 0);
`endif

    // Counter wrap while running.
    force dut.r_cyc_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_cyc_cnt;
    m_cnt = 32'hFFFF_FFFE;
    chk("preload", cyc_cnt, 32'hFFFF_FFFE);
    tick();
    chk("wrap_m1", cyc_cnt, 32'hFFFF_FFFF);
    tick();
    chk("wrap_0", cyc_cnt, 32'h0);
    tick();
    chk("wrap_1", cyc_cnt, 32'h1);
    cnt_clr = 1; tick();
    chk("clr_with_inc", cyc_cnt, 32'h0);

    // Reset in the middle of RUN, then re-entry through the synchronizer.
    chk("pre_rst_en", {31'd0, cpu_en}, 1);
    rst_n = 0; model_reset();
    #1;
    check_all();
    chk("rst_en_now", {31'd0, cpu_en}, 0);
    chk("rst_cnt_now", cyc_cnt, 0);
    tick(); tick();
    rst_n = 1;
    tick(); chk("rel_edge1", {31'd0, cpu_en}, 0);
    tick(); chk("rel_edge2", {31'd0, cpu_en}, 0);
    tick(); chk("rel_edge3", {31'd0, cpu_en}, 1);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) run = ~run;
      if ($urandom_range(0, 2) == 0) step = ~step;
      pc = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      if ($urandom_range(0, 15) == 0) begin
        brk_set = 1; brk_wdata = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      end
      if ($urandom_range(0, 31) == 0) brk_clr = 1;
      if ($urandom_range(0, 31) == 0) cnt_clr = 1;
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 0; model_reset();
        #1;
        check_all();
        rst_n = 1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
